// File: rtl/pe_array_ctrl.sv
// Job sequencer for the 8x8 PE array: loads a weight block, streams input vectors,
// and writes each returned output vector to the output buffer.
module pe_array_ctrl #(
  parameter int unsigned row       = 8,
  parameter int unsigned addr_bw   = 11,
  parameter int unsigned len_bw    = 8,
  parameter int unsigned drain_max = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_mode,
  input  logic [len_bw-1:0]  cfg_len,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_x_base,
  input  logic [addr_bw-1:0] cfg_o_base,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               w_rd_en,
  output logic [addr_bw-1:0] w_rd_addr,
  output logic               x_rd_en,
  output logic [addr_bw-1:0] x_rd_addr,
  output logic               arr_mode,
  output logic               arr_weight_valid,
  output logic               arr_input_valid,
  input  logic               arr_valid_out,
  output logic               o_wr_en,
  output logic [addr_bw-1:0] o_wr_addr
);

  localparam int unsigned WCntW = $clog2(row) + 1;
  localparam int unsigned DCntW = $clog2(drain_max) + 1;
  localparam logic [WCntW-1:0] WLast = WCntW'(row - 1);
  localparam logic [DCntW-1:0] DLast = DCntW'(drain_max - 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic               mode_q;
  logic [len_bw-1:0]  len_q;
  logic [addr_bw-1:0] w_base_q, x_base_q, o_base_q;
  logic [WCntW-1:0]   w_cnt_q, w_cnt_d;
  logic [len_bw-1:0]  x_cnt_q, x_cnt_d;
  logic [len_bw-1:0]  out_cnt_q, out_cnt_d;
  logic [DCntW-1:0]   drain_cnt_q, drain_cnt_d;
  logic               err_q, err_d;
  logic               wv_q, iv_q;
  logic               accept;
  logic               capture;

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    x_cnt_d     = x_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    accept      = 1'b0;
    w_rd_en     = 1'b0;
    x_rd_en     = 1'b0;
    o_wr_en     = 1'b0;
    done        = 1'b0;

    capture = ((state_q == StStream) || (state_q == StDrain)) && arr_valid_out &&
              (out_cnt_q < len_q);
    if (capture) begin
      o_wr_en   = 1'b1;
      out_cnt_d = out_cnt_q + len_bw'(1);
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          accept      = 1'b1;
          err_d       = 1'b0;
          w_cnt_d     = '0;
          x_cnt_d     = '0;
          out_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = StLoadW;
        end
      end
      StLoadW: begin
        if (!stall) begin
          w_rd_en = 1'b1;
          w_cnt_d = w_cnt_q + WCntW'(1);
          if (w_cnt_q == WLast) begin
            state_d = (len_q == '0) ? StDone : StStream;
          end
        end
      end
      StStream: begin
        if (!stall) begin
          x_rd_en = 1'b1;
          x_cnt_d = x_cnt_q + len_bw'(1);
          if (x_cnt_q == len_q - len_bw'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + DCntW'(1);
        // Compare against the post-capture count so done follows the last write directly.
        if (out_cnt_d == len_q) begin
          state_d = StDone;
        end else if (drain_cnt_q == DLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      len_q       <= '0;
      w_base_q    <= '0;
      x_base_q    <= '0;
      o_base_q    <= '0;
      w_cnt_q     <= '0;
      x_cnt_q     <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
      wv_q        <= 1'b0;
      iv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      x_cnt_q     <= x_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
      wv_q        <= w_rd_en;
      iv_q        <= x_rd_en;
      if (accept) begin
        mode_q   <= cfg_mode;
        len_q    <= cfg_len;
        w_base_q <= cfg_w_base;
        x_base_q <= cfg_x_base;
        o_base_q <= cfg_o_base;
      end
    end
  end

  // Addresses read as zero whenever their enable is low.
  assign w_rd_addr = w_rd_en ? w_base_q + addr_bw'(w_cnt_q) : '0;
  assign x_rd_addr = x_rd_en ? x_base_q + addr_bw'(x_cnt_q) : '0;
  assign o_wr_addr = o_wr_en ? o_base_q + addr_bw'(out_cnt_q) : '0;

  assign busy             = (state_q != StIdle);
  assign err              = err_q;
  assign arr_mode         = mode_q;
  assign arr_weight_valid = wv_q;
  assign arr_input_valid  = iv_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl with a 3-cycle array latency model and a per-job monitor.
module tb_pe_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic [10:0] cfg_w_base = '0;
  logic [10:0] cfg_x_base = '0;
  logic [10:0] cfg_o_base = '0;
  logic        stall = 1'b0;
  logic        busy, done, err;
  logic        w_rd_en, x_rd_en, o_wr_en;
  logic [10:0] w_rd_addr, x_rd_addr, o_wr_addr;
  logic        arr_mode, arr_weight_valid, arr_input_valid;
  logic        arr_valid_out;

  pe_array_ctrl #(
    .row      (8),
    .addr_bw  (11),
    .len_bw   (8),
    .drain_max(64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_mode        (cfg_mode),
    .cfg_len         (cfg_len),
    .cfg_w_base      (cfg_w_base),
    .cfg_x_base      (cfg_x_base),
    .cfg_o_base      (cfg_o_base),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .w_rd_en         (w_rd_en),
    .w_rd_addr       (w_rd_addr),
    .x_rd_en         (x_rd_en),
    .x_rd_addr       (x_rd_addr),
    .arr_mode        (arr_mode),
    .arr_weight_valid(arr_weight_valid),
    .arr_input_valid (arr_input_valid),
    .arr_valid_out   (arr_valid_out),
    .o_wr_en         (o_wr_en),
    .o_wr_addr       (o_wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Array model: each input strobe returns an output 3 cycles later, up to ret_limit per job.
  logic [2:0] pipe = '0;
  int         ret_cnt = 0;
  int         ret_limit = 4;
  logic       extra_vo = 1'b0;

  always @(posedge clk) begin
    if (reset || (start && !busy)) begin
      pipe    <= '0;
      ret_cnt <= 0;
    end else begin
      pipe <= {pipe[1:0], arr_input_valid};
      if (pipe[2] && ret_cnt < ret_limit) ret_cnt <= ret_cnt + 1;
    end
  end

  assign arr_valid_out = (pipe[2] && (ret_cnt < ret_limit)) || extra_vo;

  // Monitor: cycle index relative to the accepted start (cycle 0) and per-job logs.
  int          cyc = 0;
  int          n_w = 0, n_x = 0, n_o = 0, n_wv = 0, n_iv = 0, n_done = 0, n_busy = 0;
  int          first_w = -1, first_wv = -1, first_x = -1;
  logic        err_at1 = 1'b0;
  logic [10:0] w_log[16];
  logic [10:0] x_log[16];
  logic [10:0] o_log[16];

  always @(negedge clk) begin
    if (start && !busy && !reset) begin
      cyc      <= 1;
      n_w      <= 0;
      n_x      <= 0;
      n_o      <= 0;
      n_wv     <= 0;
      n_iv     <= 0;
      n_done   <= 0;
      n_busy   <= 0;
      first_w  <= -1;
      first_wv <= -1;
      first_x  <= -1;
    end else begin
      cyc <= cyc + 1;
      if (w_rd_en) begin
        if (n_w < 16) w_log[n_w] <= w_rd_addr;
        n_w <= n_w + 1;
        if (first_w < 0) first_w <= cyc;
      end
      if (x_rd_en) begin
        if (n_x < 16) x_log[n_x] <= x_rd_addr;
        n_x <= n_x + 1;
        if (first_x < 0) first_x <= cyc;
      end
      if (o_wr_en) begin
        if (n_o < 16) o_log[n_o] <= o_wr_addr;
        n_o <= n_o + 1;
      end
      if (arr_weight_valid) begin
        n_wv <= n_wv + 1;
        if (first_wv < 0) first_wv <= cyc;
      end
      if (arr_input_valid) n_iv <= n_iv + 1;
      if (done) n_done <= n_done + 1;
      if (busy) n_busy <= n_busy + 1;
      if (cyc == 1) err_at1 <= err;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle c counts from the accepted start; stall hits cycles 4,5 (LOAD_W) and 12,13 (STREAM).
  task automatic run_job(input logic mode, input logic [7:0] len, input logic [10:0] wb,
                         input logic [10:0] xb, input logic [10:0] ob, input bit stall_en,
                         input int st_a, input int st_b, input int vo_lo, input int vo_hi,
                         input int reset_at, output int done_at);
    @(posedge clk); #1;
    cfg_mode   = mode;
    cfg_len    = len;
    cfg_w_base = wb;
    cfg_x_base = xb;
    cfg_o_base = ob;
    start      = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    done_at = -1;
    for (int c = 1; c <= 200; c++) begin
      stall    = stall_en && (c == 4 || c == 5 || c == 12 || c == 13);
      start    = (c == st_a) || (c == st_b);
      extra_vo = (c >= vo_lo) && (c <= vo_hi);
      reset    = (c == reset_at);
      @(negedge clk);
      if (done && done_at < 0) done_at = c;
      if (reset_at > 0 && c == reset_at + 1) begin
        check_eq("abort_ctl", {busy, done, err, w_rd_en, x_rd_en, o_wr_en, arr_mode,
                               arr_weight_valid, arr_input_valid}, 0);
        check_eq("abort_addr", {w_rd_addr, x_rd_addr, o_wr_addr}, 0);
        break;
      end
      if (done_at > 0 && c >= done_at + 2) break;
      @(posedge clk); #1;
    end
    stall    = 1'b0;
    start    = 1'b0;
    extra_vo = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_job(input string tag, input logic [10:0] wb, input logic [10:0] xb,
                           input logic [10:0] ob, input int k, input int n_ret,
                           input int exp_done, input int done_at);
    logic [10:0] e;
    check_eq({tag, " done_at"}, done_at, exp_done);
    check_eq({tag, " n_busy"}, n_busy, exp_done);
    check_eq({tag, " n_done"}, n_done, 1);
    check_eq({tag, " busy_after"}, {31'b0, busy}, 0);
    check_eq({tag, " n_w"}, n_w, 8);
    check_eq({tag, " n_wv"}, n_wv, 8);
    check_eq({tag, " first_w"}, first_w, 1);
    check_eq({tag, " first_wv"}, first_wv, 2);
    check_eq({tag, " n_x"}, n_x, k);
    check_eq({tag, " n_iv"}, n_iv, k);
    check_eq({tag, " n_o"}, n_o, n_ret);
    for (int i = 0; i < 8; i++) begin
      e = wb + 11'(i);
      check_eq($sformatf("%s w%0d", tag, i), {21'b0, w_log[i]}, {21'b0, e});
    end
    for (int i = 0; i < k && i < 16; i++) begin
      e = xb + 11'(i);
      check_eq($sformatf("%s x%0d", tag, i), {21'b0, x_log[i]}, {21'b0, e});
    end
    for (int i = 0; i < n_ret && i < 16; i++) begin
      e = ob + 11'(i);
      check_eq($sformatf("%s o%0d", tag, i), {21'b0, o_log[i]}, {21'b0, e});
    end
  endtask

  int d;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ctl", {busy, done, err, w_rd_en, x_rd_en, o_wr_en, arr_mode,
                         arr_weight_valid, arr_input_valid}, 0);
    check_eq("rst_addr", {w_rd_addr, x_rd_addr, o_wr_addr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Nominal job
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("nom", 11'h010, 11'h020, 11'h030, 4, 4, 17, d);
    check_eq("nom first_x", first_x, 9);
    check_eq("nom err", {31'b0, err}, 0);
    check_eq("nom mode", {31'b0, arr_mode}, 1);

    // Same job with two 2-cycle stalls
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b1, -1, -1, 1, 0, -1, d);
    check_job("stall", 11'h010, 11'h020, 11'h030, 4, 4, 21, d);

    // K = 0
    run_job(1'b0, 8'd0, 11'h040, 11'h100, 11'h200, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("k0", 11'h040, 11'h100, 11'h200, 0, 0, 9, d);
    check_eq("k0 mode", {31'b0, arr_mode}, 0);

    // Address wrap on all three buffers
    run_job(1'b1, 8'd4, 11'h7FC, 11'h7FE, 11'h7FF, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("wrap", 11'h7FC, 11'h7FE, 11'h7FF, 4, 4, 17, d);

    // Drain timeout: only 3 of 4 outputs return
    ret_limit = 3;
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("tmo", 11'h010, 11'h020, 11'h030, 4, 3, 77, d);
    repeat (5) @(posedge clk);
    #1;
    check_eq("tmo err_sticky", {31'b0, err}, 1);
    ret_limit = 4;

    // Next start clears err
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("post_tmo", 11'h010, 11'h020, 11'h030, 4, 4, 17, d);
    check_eq("post_tmo err_at1", {31'b0, err_at1}, 0);
    check_eq("post_tmo err", {31'b0, err}, 0);

    // Starts in STREAM and DONE ignored; extra valid_out after the 4th write ignored
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, 10, 14, 9, 12, -1, d);
    check_job("busy_start", 11'h010, 11'h020, 11'h030, 4, 4, 14, d);

    // Reset during STREAM aborts the job
    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, -1, -1, 1, 0, 10, d);
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort n_done", n_done, 0);
    check_eq("abort busy", {31'b0, busy}, 0);

    run_job(1'b1, 8'd4, 11'h010, 11'h020, 11'h030, 1'b0, -1, -1, 1, 0, -1, d);
    check_job("post_rst", 11'h010, 11'h020, 11'h030, 4, 4, 17, d);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
